axis_video_frame_checker: RTL

Consumer end of the 32-bit AXI4-Stream video link that SyntPic/MyYCbCr sources drive: accepts pixel beats, optionally throttles `s_axis_video_tready`, and checks frame structure (start-of-frame on `tuser`, end-of-line on `tlast`, line count per frame). It reports frame completion, running counters and sticky error flags, and serves as the synthesizable sink/monitor for camera-path bring-up and for the simulation bench.

---
 rtl/video_pkg.sv | 24 ++
 rtl/axis_ready_throttle.sv | 22 ++
 rtl/axis_video_frame_checker.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video-path definitions: frame geometry defaults, checker FSM states,
// counter widths and err_sticky bit positions.
package video_pkg;

  localparam int unsigned H_PIX_DEF   = 640;
  localparam int unsigned V_LINES_DEF = 480;

  localparam int unsigned PIX_W  = 11;
  localparam int unsigned LINE_W = 10;
  localparam int unsigned FCNT_W = 16;
  localparam int unsigned ERR_W  = 4;
  localparam int unsigned SUM_W  = 32;

  localparam int unsigned ERR_EARLY_EOL = 0;
  localparam int unsigned ERR_LATE_EOL  = 1;
  localparam int unsigned ERR_UNEXP_SOF = 2;
  localparam int unsigned ERR_ABORT     = 3;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    IN_FRAME = 1'b1
  } vid_state_e;

endpackage

// File: rtl/axis_ready_throttle.sv
// Registered tready generator: free-running 2-bit phase, ready withheld on phase 3
// when stall_en is set.
module axis_ready_throttle (
  input  logic clk,
  input  logic rstn,
  input  logic stall_en,
  output logic tready
);

  logic [1:0] phase_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= 2'd0;
      tready  <= 1'b0;
    end else begin
      phase_q <= phase_q + 2'd1;
      tready  <= !(stall_en && (phase_q == 2'd3));
    end
  end

endmodule

// File: rtl/axis_video_frame_checker.sv
// AXI4-Stream video sink that checks SOF/EOL framing and counts good frames.
// Optional FRAME_CHECKSUM_EN builds a per-frame wrapping tdata sum on frame_sum.
module axis_video_frame_checker
  import video_pkg::*;
#(
  parameter int unsigned H_PIX   = H_PIX_DEF,
  parameter int unsigned V_LINES = V_LINES_DEF,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s_axis_video_tdata,
  input  logic              s_axis_video_tvalid,
  output logic              s_axis_video_tready,
  input  logic              s_axis_video_tuser,
  input  logic              s_axis_video_tlast,
  input  logic              stall_en,
  input  logic              clr,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic [LINE_W-1:0] line_cnt,
  output logic [PIX_W-1:0]  pix_cnt,
  output logic [ERR_W-1:0]  err_sticky,
  output logic [SUM_W-1:0]  frame_sum
);

  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_PIX - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_LINES - 1);

  vid_state_e        state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d, beat_pix;
  logic [LINE_W-1:0] line_q, line_d, beat_line;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              done_q, done_d;
  logic              frame_err_q, frame_err_d, beat_err;
  logic              hs, take, restart, close_line, good_end;

  axis_ready_throttle u_throttle (
    .clk      (clk),
    .rstn     (rstn),
    .stall_en (stall_en),
    .tready   (s_axis_video_tready)
  );

  assign hs = s_axis_video_tvalid & s_axis_video_tready;

  // Next-state: decide which beat is taken, its position in the frame, then close lines/frames.
  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    line_d      = line_q;
    err_d       = err_q;
    fcnt_d      = fcnt_q;
    done_d      = 1'b0;
    frame_err_d = frame_err_q;
    take        = 1'b0;
    restart     = 1'b0;
    close_line  = 1'b0;
    good_end    = 1'b0;
    beat_pix    = pix_q;
    beat_line   = line_q;
    beat_err    = frame_err_q;

    if (clr) begin
      state_d     = WAIT_SOF;
      pix_d       = '0;
      line_d      = '0;
      err_d       = '0;
      fcnt_d      = '0;
      frame_err_d = 1'b0;
    end else if (hs) begin
      if (s_axis_video_tuser) begin
        take      = 1'b1;
        restart   = 1'b1;
        beat_pix  = '0;
        beat_line = '0;
        beat_err  = 1'b0;
        if (state_q == IN_FRAME) begin
          err_d[ERR_UNEXP_SOF] = 1'b1;
          err_d[ERR_ABORT]     = 1'b1;
        end
      end else if (state_q == IN_FRAME) begin
        take = 1'b1;
      end
    end

    if (take) begin
      state_d = IN_FRAME;
      if (beat_pix == PIX_LAST) begin
        close_line = 1'b1;
        if (!s_axis_video_tlast) begin
          err_d[ERR_LATE_EOL] = 1'b1;
          beat_err            = 1'b1;
        end
      end else if (s_axis_video_tlast) begin
        close_line           = 1'b1;
        err_d[ERR_EARLY_EOL] = 1'b1;
        beat_err             = 1'b1;
      end

      if (close_line) begin
        pix_d = '0;
        if (beat_line == LINE_LAST) begin
          state_d = WAIT_SOF;
          line_d  = '0;
          if (!beat_err) begin
            good_end = 1'b1;
            done_d   = 1'b1;
            fcnt_d   = fcnt_q + FCNT_W'(1);
          end
        end else begin
          line_d = beat_line + LINE_W'(1);
        end
      end else begin
        pix_d  = beat_pix + PIX_W'(1);
        line_d = beat_line;
      end
      frame_err_d = beat_err;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= WAIT_SOF;
      pix_q       <= '0;
      line_q      <= '0;
      err_q       <= '0;
      fcnt_q      <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      line_q      <= line_d;
      err_q       <= err_d;
      fcnt_q      <= fcnt_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;
  assign line_cnt   = line_q;
  assign pix_cnt    = pix_q;
  assign err_sticky = err_q;

`ifdef FRAME_CHECKSUM_EN
  logic [SUM_W-1:0] acc_q, sum_q, acc_sum_c;

  // Running sum restarts on every SOF beat; only good frames publish it.
  assign acc_sum_c = (restart ? SUM_W'(0) : acc_q) + SUM_W'(s_axis_video_tdata);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (take) begin
      acc_q <= acc_sum_c;
      if (good_end) begin
        sum_q <= acc_sum_c;
      end
    end
  end

  assign frame_sum = sum_q;
`else
  logic unused_csum;
  assign unused_csum = ^{s_axis_video_tdata, restart, good_end};
  assign frame_sum   = '0;
`endif

endmodule
